trigger_arm_sequencer: RTL and testbench
========================================

TRIGGER_ARM_SEQUENCER -- requirements
Module: trigger_arm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`  in  1  system clock; all state changes on its rising edge.
REQ-003 Port `module_reset_n`  in  1  asynchronous, active-low reset.
REQ-004 Port `start`  in  1  request to begin a capture sequence; ignored unless in IDLE.
REQ-005 Port `abort`  in  1  terminates any sequence in progress.
REQ-006 Port `continuous`  in  1  when high, re-arms after hold-off instead of finishing.
REQ-007 Port `triggered`  in  1  latched trigger flag from the trigger control block.
REQ-008 Port `sample_valid`  in  1  one-cycle strobe per ADC sample.
REQ-009 Port `post_trigger_count`  in  16  number of samples to capture after a trigger; sampled on leaving WAIT_TRIG.
REQ-010 Port `hold_off`  in  8  idle cycles between clear and re-arm; sampled on entering HOLDOFF.
REQ-011 Port `armed`  out  1  arm enable to the trigger control block.
REQ-012 Port `manual_reset`  out  1  one-cycle clear pulse to the trigger control block.
REQ-013 Port `capture_en`  out  1  sample capture window.
REQ-014 Port `capture_done`  out  1  one-cycle completion pulse.
REQ-015 Port `busy`  out  1  high in every state except IDLE.
REQ-016 Port `trig_count`  out  16  number of triggers accepted since reset, saturating.

Function
REQ-017 FSM states: IDLE, CLR0, ARM, WAIT_TRIG, CAPTURE, CLEAR, HOLDOFF, DONE.
REQ-018 IDLE -> CLR0 on `start`=1; otherwise stays in IDLE.
REQ-019 CLR0: `manual_reset`=1 for exactly 1 cycle, `armed`=0; unconditionally -> ARM.
REQ-020 ARM: `armed`=1, `triggered` ignored; after 1 cycle -> WAIT_TRIG.
REQ-021 WAIT_TRIG: `armed`=1 held.
  - On `triggered`=1: `trig_count` increments (saturates at 0xFFFF), `armed` drops the next cycle, and the sample counter loads `post_trigger_count`.
  - Next state is CAPTURE if the loaded count is nonzero, else CLEAR.
REQ-022 CAPTURE: `capture_en`=1.
  - Each `sample_valid`=1 cycle decrements the counter.
  - The cycle in which the counter goes 1 -> 0 is the last cycle with `capture_en`=1; the next state is CLEAR.
  - Exactly N `sample_valid` strobes fall inside the `capture_en` window.
REQ-023 CLEAR: `manual_reset`=1 for exactly 1 cycle; -> HOLDOFF.
REQ-024 HOLDOFF: stays for `hold_off` cycles (0 means one pass-through cycle).
  - At expiry: -> CLR0 if `continuous`=1, else -> DONE.
  - `continuous` is sampled at expiry.
REQ-025 DONE: `capture_done`=1 for 1 cycle; -> IDLE.
REQ-026 `abort`=1 in any non-IDLE state:
  - Next state is CLEAR; `armed` and `capture_en` drop the next cycle.
  - After CLEAR the FSM returns to IDLE directly, skipping HOLDOFF and DONE; no `capture_done` pulse.
REQ-027 `abort` in IDLE has no effect.
REQ-028 If `abort` and `start` are asserted together in IDLE, `start` wins.
REQ-029 `start` outside IDLE is ignored and not queued.
REQ-030 `triggered` outside WAIT_TRIG SHALL NOT change state or `trig_count`.
REQ-031 All outputs are registered.
  - `armed`, `manual_reset` and `capture_en` are never high in the same cycle.
  - `armed` and `capture_en` are mutually exclusive by construction.

Reset
REQ-032 While `module_reset_n`=0, the block SHALL immediately (asynchronously) force:
  - state = IDLE;
  - `armed`, `manual_reset`, `capture_en`, `capture_done` and `busy` = 0;
  - `trig_count` = 0 and the internal counters = 0.
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence without a `manual_reset` pulse.
REQ-034 The first `start` is accepted on the first rising edge at which `module_reset_n`=1.

Verification
REQ-035 Single shot:
  - Stimulus: `post_trigger_count`=4, `hold_off`=3, `start` pulse, `triggered`=1 three cycles later, `sample_valid` every cycle.
  - Response: `manual_reset` 1 cycle, `armed` from cycle +2, `capture_en` exactly 4 cycles, one `manual_reset`, 3 hold-off cycles, one `capture_done`, `trig_count`=1.
REQ-036 Sparse samples:
  - Stimulus: `post_trigger_count`=3, `sample_valid` every 5th cycle.
  - Response: `capture_en` spans exactly 3 strobes and ends on the 3rd.
REQ-037 Zero count:
  - Stimulus: `post_trigger_count`=0.
  - Response: `capture_en` never high; WAIT_TRIG -> CLEAR; `capture_done` still pulses.
REQ-038 Continuous:
  - Stimulus: `continuous`=1, 3 triggers, then `continuous`=0.
  - Response: 3 capture windows, each preceded by a CLR0 pulse; `trig_count`=3; a single `capture_done` after the last window.
REQ-039 Abort during CAPTURE:
  - Response: `capture_en` drops the next cycle, one `manual_reset` pulse, return to IDLE, no `capture_done`.
  - A following `start` works normally.
REQ-040 Reset mid-WAIT_TRIG and saturation:
  - Reset mid-WAIT_TRIG: all outputs are 0 immediately, with no `manual_reset` pulse.
  - Saturation: with `trig_count` preset near 0xFFFF by repeated triggers, it holds at 0xFFFF.

Source files
------------

// File: rtl/trigger_arm_sequencer.sv
// Capture sequencer driving a trigger control block: clears the trigger
// latch, arms it, waits for a trigger, opens a capture window for a
// programmed number of samples, clears again, then either re-arms after a
// hold-off (continuous mode) or reports completion.
module trigger_arm_sequencer (
   input  logic        clk,
   input  logic        module_reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        continuous,
   input  logic        triggered,
   input  logic        sample_valid,
   input  logic [15:0] post_trigger_count,
   input  logic [7:0]  hold_off,
   output logic        armed,
   output logic        manual_reset,
   output logic        capture_en,
   output logic        capture_done,
   output logic        busy,
   output logic [15:0] trig_count
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CLR0      = 3'd1;
   localparam logic [2:0] ARM       = 3'd2;
   localparam logic [2:0] WAIT_TRIG = 3'd3;
   localparam logic [2:0] CAPTURE   = 3'd4;
   localparam logic [2:0] CLEAR     = 3'd5;
   localparam logic [2:0] HOLDOFF   = 3'd6;
   localparam logic [2:0] DONE      = 3'd7;

   logic [2:0]  state_reg, state_next;
   logic [15:0] sample_cnt_reg, sample_cnt_next;
   logic [7:0]  hold_cnt_reg, hold_cnt_next;
   logic [15:0] trig_count_reg, trig_count_next;
   logic        aborted_reg, aborted_next;

   logic        armed_reg, armed_next;
   logic        manual_reset_reg, manual_reset_next;
   logic        capture_en_reg, capture_en_next;
   logic        capture_done_reg, capture_done_next;
   logic        busy_reg, busy_next;

   // Next-state, counter and output decode; outputs are decoded from the
   // next state so the registered outputs line up with the state register.
   always_comb begin
      state_next      = state_reg;
      sample_cnt_next = sample_cnt_reg;
      hold_cnt_next   = hold_cnt_reg;
      trig_count_next = trig_count_reg;
      aborted_next    = aborted_reg;

      if (abort && (state_reg != IDLE)) begin
         // Abort wins over everything outside IDLE, including a trigger
         // arriving in the same cycle; the clear cycle then returns to IDLE.
         state_next   = CLEAR;
         aborted_next = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next   = CLR0;
                  aborted_next = 1'b0;
               end
            end
            CLR0:      state_next = ARM;
            ARM:       state_next = WAIT_TRIG;
            WAIT_TRIG: begin
               if (triggered) begin
                  sample_cnt_next = post_trigger_count;
                  if (trig_count_reg != 16'hFFFF) begin
                     trig_count_next = trig_count_reg + 16'd1;
                  end
                  state_next = (post_trigger_count != 16'd0) ? CAPTURE : CLEAR;
               end
            end
            CAPTURE: begin
               // The strobe that takes the count 1 -> 0 is the last one
               // inside the window.
               if (sample_valid) begin
                  sample_cnt_next = sample_cnt_reg - 16'd1;
                  if (sample_cnt_reg <= 16'd1) begin
                     state_next = CLEAR;
                  end
               end
            end
            CLEAR: begin
               if (aborted_reg) begin
                  state_next   = IDLE;
                  aborted_next = 1'b0;
               end else begin
                  state_next    = HOLDOFF;
                  hold_cnt_next = hold_off;
               end
            end
            HOLDOFF: begin
               // A loaded value of 0 or 1 both give a single hold-off cycle.
               if (hold_cnt_reg <= 8'd1) begin
                  state_next = continuous ? CLR0 : DONE;
               end else begin
                  hold_cnt_next = hold_cnt_reg - 8'd1;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end

      armed_next        = (state_next == ARM) || (state_next == WAIT_TRIG);
      manual_reset_next = (state_next == CLR0) || (state_next == CLEAR);
      capture_en_next   = (state_next == CAPTURE);
      capture_done_next = (state_next == DONE);
      busy_next         = (state_next != IDLE);
   end

   // State, counters and registered outputs; reset abandons any sequence
   // without issuing a clear pulse.
   always_ff @(posedge clk or negedge module_reset_n) begin
      if (!module_reset_n) begin
         state_reg        <= IDLE;
         sample_cnt_reg   <= 16'd0;
         hold_cnt_reg     <= 8'd0;
         trig_count_reg   <= 16'd0;
         aborted_reg      <= 1'b0;
         armed_reg        <= 1'b0;
         manual_reset_reg <= 1'b0;
         capture_en_reg   <= 1'b0;
         capture_done_reg <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         sample_cnt_reg   <= sample_cnt_next;
         hold_cnt_reg     <= hold_cnt_next;
         trig_count_reg   <= trig_count_next;
         aborted_reg      <= aborted_next;
         armed_reg        <= armed_next;
         manual_reset_reg <= manual_reset_next;
         capture_en_reg   <= capture_en_next;
         capture_done_reg <= capture_done_next;
         busy_reg         <= busy_next;
      end
   end

   assign armed        = armed_reg;
   assign manual_reset = manual_reset_reg;
   assign capture_en   = capture_en_reg;
   assign capture_done = capture_done_reg;
   assign busy         = busy_reg;
   assign trig_count   = trig_count_reg;

endmodule

// File: tb/tb_trigger_arm_sequencer.sv
// Directed bench for trigger_arm_sequencer: a table of capture scenarios
// with hand-computed event counts, plus hand-written abort, reset and
// saturation sequences.
module tb_trigger_arm_sequencer;

   logic        clk;
   logic        module_reset_n;
   logic        start, abort, continuous, triggered, sample_valid;
   logic [15:0] post_trigger_count;
   logic [7:0]  hold_off;
   logic        armed, manual_reset, capture_en, capture_done, busy;
   logic [15:0] trig_count;

   trigger_arm_sequencer dut (
      .clk                (clk),
      .module_reset_n     (module_reset_n),
      .start              (start),
      .abort              (abort),
      .continuous         (continuous),
      .triggered          (triggered),
      .sample_valid       (sample_valid),
      .post_trigger_count (post_trigger_count),
      .hold_off           (hold_off),
      .armed              (armed),
      .manual_reset       (manual_reset),
      .capture_en         (capture_en),
      .capture_done       (capture_done),
      .busy               (busy),
      .trig_count         (trig_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int post;
      int hold;
      bit cont;
      int period;   // sample_valid every Nth cycle, 0 = never
      int ntrig;
      int delay;    // cycles after armed rises before raising triggered
      int exp_cap;  // capture_en cycles, -1 = not fixed by the stimulus
      int exp_strb;
      int exp_win;
      int exp_end;
      int exp_mr;
      int exp_done;
      int exp_hold;
   } vec_t;

   vec_t vecs [6];

   int n_chk  = 0;
   int n_pass = 0;
   int exp_trig = 0;
   int excl_err = 0;
   int m_cap, m_strb, m_win, m_end, m_mr, m_done, m_hold;
   bit prev_cap, prev_strb;
   int sv_period = 0;
   int sv_phase  = 0;
   bit timed_out;

   task automatic check(input string name, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
   endtask

   task automatic clear_mon();
      m_cap = 0; m_strb = 0; m_win = 0; m_end = 0;
      m_mr = 0; m_done = 0; m_hold = 0;
   endtask

   // One clock: observe outputs on the falling edge, then step to 2 time
   // units after the next rising edge and update the sample strobe.
   task automatic tick();
      @(negedge clk);
      if (armed && capture_en)        excl_err++;
      if (armed && manual_reset)      excl_err++;
      if (manual_reset && capture_en) excl_err++;
      if (capture_en) m_cap++;
      if (capture_en && sample_valid) m_strb++;
      if (capture_en && !prev_cap) m_win++;
      if (!capture_en && prev_cap && prev_strb) m_end++;
      prev_cap  = capture_en;
      prev_strb = capture_en && sample_valid;
      if (manual_reset) m_mr++;
      if (capture_done) m_done++;
      if (busy && !armed && !manual_reset && !capture_en && !capture_done) m_hold++;
      @(posedge clk);
      #2;
      if (sv_period > 0) begin
         sample_valid = (sv_phase == 0);
         sv_phase = (sv_phase + 1 == sv_period) ? 0 : sv_phase + 1;
      end else begin
         sample_valid = 1'b0;
      end
   endtask

   task automatic wait_armed();
      int g = 0;
      while (!armed && g < 200) begin tick(); g++; end
      if (!armed) timed_out = 1'b1;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int lat, g;
      v = vecs[i];
      post_trigger_count = v.post[15:0];
      hold_off   = v.hold[7:0];
      continuous = v.cont;
      sv_period  = v.period;
      sv_phase   = 0;
      timed_out  = 1'b0;
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      while (!armed && lat < 20) begin tick(); lat++; end
      for (int t = 0; t < v.ntrig; t++) begin
         wait_armed();
         for (int d = 0; d < v.delay; d++) tick();
         triggered = 1'b1;
         g = 0;
         while (armed && g < 100) begin tick(); g++; end
         if (armed) timed_out = 1'b1;
         triggered = 1'b0;
         if (t == v.ntrig - 1) continuous = 1'b0;
      end
      g = 0;
      while (busy && g < 500) begin tick(); g++; end
      if (busy) timed_out = 1'b1;
      exp_trig = exp_trig + v.ntrig;
      if (exp_trig > 65535) exp_trig = 65535;
      sv_period = 0;
      $display("vec %0d: post=%0d hold=%0d cont=%0d trig=%0d -> lat=%0d cap=%0d strb=%0d win=%0d mr=%0d done=%0d hold=%0d count=%0d",
               i, v.post, v.hold, v.cont, v.ntrig, lat, m_cap, m_strb, m_win, m_mr, m_done, m_hold, trig_count);
      check($sformatf("v%0d timeout", i), int'(timed_out), 0);
      check($sformatf("v%0d arm_latency", i), lat, 2);
      if (v.exp_cap >= 0) check($sformatf("v%0d capture_cycles", i), m_cap, v.exp_cap);
      check($sformatf("v%0d strobes_in_window", i), m_strb, v.exp_strb);
      check($sformatf("v%0d windows", i), m_win, v.exp_win);
      check($sformatf("v%0d windows_end_on_strobe", i), m_end, v.exp_end);
      check($sformatf("v%0d manual_reset_cycles", i), m_mr, v.exp_mr);
      check($sformatf("v%0d capture_done", i), m_done, v.exp_done);
      check($sformatf("v%0d holdoff_cycles", i), m_hold, v.exp_hold);
      check($sformatf("v%0d trig_count", i), int'(trig_count), exp_trig);
   endtask

   initial begin
      //          post hold cont per ntrig dly  cap strb win end mr done hold
      vecs[0] = '{4,   3,   0,   1,  1,    1,   4,  4,   1,  1,  2, 1,   3};
      vecs[1] = '{3,   2,   0,   5,  1,    1,  -1,  3,   1,  1,  2, 1,   2};
      vecs[2] = '{0,   0,   0,   1,  1,    1,   0,  0,   0,  0,  2, 1,   1};
      vecs[3] = '{2,   3,   1,   1,  3,    1,   6,  6,   3,  3,  6, 1,   9};
      vecs[4] = '{1,   0,   1,   3,  2,    0,  -1,  2,   2,  2,  4, 1,   2};
      vecs[5] = '{0,   0,   1,   0,  3,    1,   0,  0,   0,  0,  6, 1,   3};

      module_reset_n = 1'b0;
      start = 1'b0; abort = 1'b0; continuous = 1'b0; triggered = 1'b0;
      sample_valid = 1'b0; post_trigger_count = 16'd0; hold_off = 8'd0;
      prev_cap = 1'b0; prev_strb = 1'b0;
      clear_mon();

      // Reset state, then the first start on the first edge out of reset.
      #12;
      check("reset armed", int'(armed), 0);
      check("reset manual_reset", int'(manual_reset), 0);
      check("reset capture_en", int'(capture_en), 0);
      check("reset capture_done", int'(capture_done), 0);
      check("reset busy", int'(busy), 0);
      check("reset trig_count", int'(trig_count), 0);
      start = 1'b1;
      #8 module_reset_n = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      check("first start manual_reset", int'(manual_reset), 1);
      check("first start busy", int'(busy), 1);
      $display("first start after reset: manual_reset=%0d busy=%0d", manual_reset, busy);

      // Abort while armed: clear next cycle, then IDLE with no done pulse.
      clear_mon();
      tick();
      check("ARM armed", int'(armed), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort in ARM armed", int'(armed), 0);
      check("abort in ARM manual_reset", int'(manual_reset), 1);
      tick();
      check("abort in ARM idle", int'(busy), 0);
      tick();
      check("abort in ARM capture_done", m_done, 0);
      $display("abort in ARM: done=%0d busy=%0d", m_done, busy);

      for (int i = 0; i < 5; i++) run_vec(i);

      // Abort during CAPTURE, followed by a normal single shot.
      post_trigger_count = 16'd10; hold_off = 8'd2; continuous = 1'b0;
      sv_period = 1; sv_phase = 0; timed_out = 1'b0;
      clear_mon();
      start = 1'b1; tick(); start = 1'b0;
      wait_armed();
      tick();
      triggered = 1'b1;
      tick();
      triggered = 1'b0;
      exp_trig++;
      check("capture window open", int'(capture_en), 1);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort capture_en drop", int'(capture_en), 0);
      check("abort manual_reset", int'(manual_reset), 1);
      tick();
      check("abort back to idle", int'(busy), 0);
      tick(); tick();
      check("abort no capture_done", m_done, 0);
      check("abort one clear pulse", m_mr, 2);
      check("abort timeout", int'(timed_out), 0);
      check("abort trig_count", int'(trig_count), exp_trig);
      sv_period = 0;
      $display("abort in CAPTURE: cap=%0d mr=%0d done=%0d count=%0d", m_cap, m_mr, m_done, trig_count);
      run_vec(0);

      // Trigger and abort in IDLE, start+abort together, start while busy.
      triggered = 1'b1;
      tick(); tick(); tick();
      triggered = 1'b0;
      check("idle trigger ignored count", int'(trig_count), exp_trig);
      check("idle trigger ignored busy", int'(busy), 0);
      abort = 1'b1; tick(); abort = 1'b0;
      check("idle abort no effect", int'(busy), 0);
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      check("start beats abort", int'(manual_reset), 1);
      tick();
      start = 1'b1; tick(); start = 1'b0;
      abort = 1'b1; tick(); abort = 1'b0;
      tick(); tick(); tick();
      check("busy start not queued", int'(busy), 0);
      $display("idle/busy corner sequence: busy=%0d count=%0d", busy, trig_count);

      // Asynchronous reset in WAIT_TRIG.
      post_trigger_count = 16'd4; hold_off = 8'd1;
      start = 1'b1; tick(); start = 1'b0;
      wait_armed();
      tick();
      clear_mon();
      #1 module_reset_n = 1'b0;
      #1;
      check("async reset armed", int'(armed), 0);
      check("async reset busy", int'(busy), 0);
      check("async reset manual_reset", int'(manual_reset), 0);
      check("async reset trig_count", int'(trig_count), 0);
      tick(); tick(); tick();
      check("reset no clear pulse", m_mr, 0);
      module_reset_n = 1'b1;
      exp_trig = 0;
      tick();
      check("after reset idle", int'(busy), 0);
      $display("reset in WAIT_TRIG: armed=%0d busy=%0d count=%0d", armed, busy, trig_count);

      // Saturation: preset the counter just below the limit.
      force dut.trig_count_reg = 16'hFFFD;
      tick();
      release dut.trig_count_reg;
      tick();
      exp_trig = 16'hFFFD;
      check("preset trig_count", int'(trig_count), exp_trig);
      run_vec(5);

      check("armed/clear/capture exclusive", excl_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
